// File: rtl/wrap_mon_pkg.sv
// wrap_mon_pkg: shared state encoding, width default and direction codes
package wrap_mon_pkg;
    localparam int EVT_W_DEF = 8;
    localparam logic UP = 1'b0;
    localparam logic DOWN = 1'b1;
    typedef enum logic [1:0] {IDLE, ARMED, PENDING} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc && value != '1)
            value <= value + 1'b1;
endmodule

// File: rtl/wrap_event_monitor.sv
// wrap_event_monitor: qualifies counter wrap events, keeps per-direction stats
// and raises a thresholded level interrupt with ack handshake and overrun flag
module wrap_event_monitor
    import wrap_mon_pkg::*;
#(
    parameter int EVT_W = EVT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_enable,
    input  logic             cnt_mode,
    input  logic             tc_in,
    input  logic             arm,
    input  logic [EVT_W-1:0] threshold,
    input  logic             irq_ack,
    input  logic             clr,
    output logic             irq,
    output logic             overrun,
    output logic [EVT_W-1:0] up_wraps,
    output logic [EVT_W-1:0] down_wraps,
    output logic [EVT_W-1:0] win_cnt
);
    logic             en_q, dir_q, evt, hit;
    logic [EVT_W-1:0] nxt;
    state_t           state;
    // tc_in is registered by the counter, so the enable/mode that caused the
    // wrap are the values sampled one edge earlier
    assign evt = tc_in & en_q;
    assign nxt = win_cnt + 1'b1;
    assign hit = evt && threshold != '0 && nxt == threshold;
    sat_counter #(.W(EVT_W)) u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (evt && dir_q == UP),
        .clr   (clr),
        .value (up_wraps)
    );
    sat_counter #(.W(EVT_W)) u_down (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (evt && dir_q == DOWN),
        .clr   (clr),
        .value (down_wraps)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            dir_q   <= 1'b0;
            state   <= IDLE;
            irq     <= 1'b0;
            overrun <= 1'b0;
            win_cnt <= '0;
        end else begin
            en_q  <= cnt_enable;
            dir_q <= cnt_mode;
            if (!arm) begin
                state   <= IDLE;
                irq     <= 1'b0;
                win_cnt <= '0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED:
                        if (hit) begin
                            win_cnt <= '0;
                            irq     <= 1'b1;
                            state   <= PENDING;
                        end else if (evt) begin
                            win_cnt <= nxt;
                        end
                    PENDING:
                        // a hit coinciding with ack re-fires instead of overrunning
                        if (hit) begin
                            win_cnt <= '0;
                            if (!irq_ack) overrun <= 1'b1;
                        end else begin
                            if (evt) win_cnt <= nxt;
                            if (irq_ack) begin
                                irq   <= 1'b0;
                                state <= ARMED;
                            end
                        end
                    default: state <= IDLE;
                endcase
            end
            if (clr) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wrap_event_monitor.sv
// tb_wrap_event_monitor: table-driven vectors plus counter-driven corner sequences
module tb_wrap_event_monitor;
    logic       clk, rst_n, cnt_enable, cnt_mode, tc_in, arm, irq_ack, clr;
    logic [7:0] threshold;
    logic       irq, overrun;
    logic [7:0] up_wraps, down_wraps, win_cnt;
    logic [3:0] cnt;
    int         n_chk, n_fail;

    typedef struct {
        logic       en, mode, tc, arm, ack, clr;
        logic [7:0] thr;
        logic       irq, ovr;
        logic [7:0] up, dn, win;
    } vec_t;
    vec_t vecs[25];

    wrap_event_monitor #(.EVT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_enable (cnt_enable),
        .cnt_mode   (cnt_mode),
        .tc_in      (tc_in),
        .arm        (arm),
        .threshold  (threshold),
        .irq_ack    (irq_ack),
        .clr        (clr),
        .irq        (irq),
        .overrun    (overrun),
        .up_wraps   (up_wraps),
        .down_wraps (down_wraps),
        .win_cnt    (win_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, mode, tc, a, ack, c, input logic [7:0] thr,
                                input logic i, o, input logic [7:0] u, d, w);
        vec_t r;
        r.en = en; r.mode = mode; r.tc = tc; r.arm = a; r.ack = ack; r.clr = c; r.thr = thr;
        r.irq = i; r.ovr = o; r.up = u; r.dn = d; r.win = w;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int idx, input logic i, o,
                           input logic [7:0] u, d, w);
        chk({nm, ".irq"}, idx, {7'd0, irq}, {7'd0, i});
        chk({nm, ".overrun"}, idx, {7'd0, overrun}, {7'd0, o});
        chk({nm, ".up"}, idx, up_wraps, u);
        chk({nm, ".down"}, idx, down_wraps, d);
        chk({nm, ".win"}, idx, win_cnt, w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // behavioural 4-bit counter with registered terminal count, held while disabled
    task automatic cnt_tick(input logic en, input logic m, input int n);
        for (int i = 0; i < n; i++) begin
            cnt_enable = en;
            cnt_mode   = m;
            step();
            if (en) begin
                tc_in = m ? (cnt == 4'd0) : (cnt == 4'd15);
                cnt   = m ? cnt - 4'd1 : cnt + 4'd1;
            end
        end
    endtask

    task automatic wrap_run(input logic m);
        int k;
        k = 0;
        do begin
            cnt_tick(1'b1, m, 1);
            k++;
        end while (!tc_in && k < 20);
        n_chk++;
        if (!tc_in) begin
            n_fail++;
            $display("FAIL wrap_run: got no wrap within %0d ticks expected a wrap", k);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; cnt_enable = 1'b0; cnt_mode = 1'b0; tc_in = 1'b0;
        arm = 1'b0; irq_ack = 1'b0; clr = 1'b0; threshold = 8'd0; cnt = 4'd0;
        // en mode tc arm ack clr thr | irq ovr up dn win
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 1, 0, 0, 3, 0, 0, 1, 0, 1);
        vecs[3]  = mk(1, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0, 1);
        vecs[4]  = mk(1, 0, 1, 1, 0, 0, 3, 0, 0, 2, 0, 2);
        vecs[5]  = mk(1, 0, 1, 1, 0, 0, 3, 1, 0, 3, 0, 0);
        vecs[6]  = mk(1, 0, 0, 1, 1, 0, 3, 0, 0, 3, 0, 0);
        vecs[7]  = mk(1, 0, 0, 1, 1, 0, 3, 0, 0, 3, 0, 0);
        vecs[8]  = mk(1, 1, 0, 1, 0, 0, 2, 0, 0, 3, 0, 0);
        vecs[9]  = mk(1, 1, 1, 1, 0, 0, 2, 0, 0, 3, 1, 1);
        vecs[10] = mk(1, 1, 1, 1, 0, 0, 2, 1, 0, 3, 2, 0);
        vecs[11] = mk(1, 1, 1, 1, 0, 0, 2, 1, 0, 3, 3, 1);
        vecs[12] = mk(1, 1, 1, 1, 0, 0, 2, 1, 1, 3, 4, 0);
        vecs[13] = mk(1, 1, 1, 1, 0, 0, 2, 1, 1, 3, 5, 1);
        vecs[14] = mk(1, 1, 1, 1, 1, 0, 2, 1, 1, 3, 6, 0);
        vecs[15] = mk(1, 1, 0, 1, 1, 0, 2, 0, 1, 3, 6, 0);
        vecs[16] = mk(1, 1, 1, 1, 0, 1, 2, 0, 0, 0, 0, 1);
        vecs[17] = mk(1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 2);
        vecs[18] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2, 3);
        vecs[19] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        vecs[20] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        vecs[21] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        vecs[22] = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 4, 0);
        vecs[23] = mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 5, 0);
        vecs[24] = mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 6, 0);

        step(); step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            cnt_enable = vecs[i].en; cnt_mode = vecs[i].mode; tc_in = vecs[i].tc;
            arm = vecs[i].arm; irq_ack = vecs[i].ack; clr = vecs[i].clr; threshold = vecs[i].thr;
            step();
            chk_all("vec", i, vecs[i].irq, vecs[i].ovr, vecs[i].up, vecs[i].dn, vecs[i].win);
        end

        // free-running counter: two up wraps in 40 clocks
        tc_in = 1'b0; cnt_enable = 1'b0; arm = 1'b0; irq_ack = 1'b0; clr = 1'b1; cnt = 4'd0;
        step();
        clr = 1'b0;
        cnt_tick(1'b1, 1'b0, 40);
        chk_all("run40", 0, 0, 0, 2, 0, 0);
        // wrap then disable with tc held high: counted once
        cnt_tick(1'b1, 1'b0, 8);
        cnt_tick(1'b0, 1'b0, 5);
        chk_all("hold_tc", 0, 0, 0, 3, 0, 0);
        cnt_tick(1'b1, 1'b0, 1);
        chk_all("hold_tc", 1, 0, 0, 3, 0, 0);
        // wrap up at 1111 then mode flip wraps down at 0000
        cnt_tick(1'b1, 1'b0, 14);
        cnt_tick(1'b1, 1'b0, 1);
        cnt_tick(1'b1, 1'b1, 1);
        chk_all("b2b", 0, 0, 0, 4, 0, 0);
        cnt_tick(1'b1, 1'b1, 1);
        chk_all("b2b", 1, 0, 0, 4, 1, 0);

        // threshold 3 over counter wraps
        clr = 1'b1;
        cnt_tick(1'b0, 1'b1, 1);
        clr = 1'b0;
        chk_all("clr", 0, 0, 0, 0, 0, 0);
        arm = 1'b1; threshold = 8'd3;
        wrap_run(1'b1); wrap_run(1'b1); wrap_run(1'b1);
        chk_all("thr3", 0, 0, 0, 0, 2, 2);
        cnt_tick(1'b1, 1'b1, 1);
        chk_all("thr3", 1, 1, 0, 0, 3, 0);
        irq_ack = 1'b1;
        cnt_tick(1'b1, 1'b1, 1);
        irq_ack = 1'b0;
        chk_all("ack", 0, 0, 0, 0, 3, 0);

        // threshold 2: fire, overrun, ack coinciding with hit
        threshold = 8'd2;
        wrap_run(1'b1); wrap_run(1'b1);
        cnt_tick(1'b1, 1'b1, 1);
        chk_all("thr2", 0, 1, 0, 0, 5, 0);
        wrap_run(1'b1); wrap_run(1'b1);
        cnt_tick(1'b1, 1'b1, 1);
        chk_all("ovr", 0, 1, 1, 0, 7, 0);
        wrap_run(1'b1); wrap_run(1'b1);
        irq_ack = 1'b1;
        cnt_tick(1'b1, 1'b1, 1);
        irq_ack = 1'b0;
        chk_all("ack_hit", 0, 1, 1, 0, 9, 0);
        clr = 1'b1;
        cnt_tick(1'b1, 1'b1, 1);
        clr = 1'b0;
        chk_all("clr2", 0, 1, 0, 0, 0, 0);

        // saturation
        arm = 1'b0; clr = 1'b1; cnt_enable = 1'b0; tc_in = 1'b0; cnt_mode = 1'b0;
        step();
        clr = 1'b0; cnt_enable = 1'b1; tc_in = 1'b1;
        repeat (300) step();
        tc_in = 1'b0;
        step();
        chk_all("sat", 0, 0, 0, 255, 0, 0);

        // asynchronous reset while PENDING
        arm = 1'b1; threshold = 8'd1;
        step();
        tc_in = 1'b1;
        step();
        tc_in = 1'b0;
        chk_all("pend", 0, 1, 0, 255, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        tc_in = 1'b1; cnt_enable = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        step();
        tc_in = 1'b0;
        chk_all("release", 0, 0, 0, 0, 0, 0);
        step();
        chk_all("release", 1, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
